// File: rtl/axi_wr_responder.sv
// AXI4 write-channel responder: terminates AW/W/B and issues one memory
// write request per strobed beat on a req/gnt port. One transaction at a time.
// Optional feature macro: AXI_WR_RESP_BURST_EN (multi-beat INCR bursts).
// Without it only single-beat writes reach memory; longer bursts are drained
// and answered with SLVERR.
//
// state | meaning
// IDLE  | waiting for AW, aw_ready_o high
// DATA  | waiting for a W beat, w_ready_o high
// MEM   | memory write request pending, mem_* held until grant
// RESP  | B response pending, b_* held until b_ready_i
module axi_wr_responder #(
    parameter int AxiIdWidth   = 4,
    parameter int AxiAddrWidth = 64,
    parameter int AxiDataWidth = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AxiIdWidth-1:0]     aw_id_i,
    input  logic [AxiAddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    input  logic [AxiDataWidth/8-1:0] w_strb_i,
    input  logic                      w_last_i,
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    output logic [AxiIdWidth-1:0]     b_id_o,
    output logic [1:0]                b_resp_o,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    output logic [AxiAddrWidth-1:0]   mem_addr_o,
    output logic [AxiDataWidth-1:0]   mem_wdata_o,
    output logic [AxiDataWidth/8-1:0] mem_be_o
);

    localparam int StrbWidth = AxiDataWidth / 8;
    localparam logic [AxiAddrWidth-1:0] BeatBytes = AxiAddrWidth'(StrbWidth);
    localparam logic [AxiAddrWidth-1:0] AddrMask  = ~(BeatBytes - 1'b1);

    typedef enum logic [1:0] {IDLE, DATA, MEM, RESP} state_t;

    state_t                   state_q;
    logic [AxiIdWidth-1:0]    id_q;
    logic [AxiAddrWidth-1:0]  addr_q;
    logic [AxiDataWidth-1:0]  wdata_q;
    logic [StrbWidth-1:0]     be_q;
    logic                     err_q;

`ifdef AXI_WR_RESP_BURST_EN
    logic [7:0] len_q;
    logic [7:0] cnt_q;
    logic       beat_last;

    assign beat_last = (cnt_q == len_q);
`else
    // Set when the burst is longer than one beat: beats are drained, not written.
    logic       multi_q;
`endif

    // Transaction FSM with all datapath latches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
`ifdef AXI_WR_RESP_BURST_EN
            len_q   <= '0;
            cnt_q   <= '0;
`else
            multi_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_valid_i) begin
                        id_q    <= aw_id_i;
                        addr_q  <= aw_addr_i & AddrMask;
`ifdef AXI_WR_RESP_BURST_EN
                        len_q   <= aw_len_i;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
`else
                        multi_q <= (aw_len_i != '0);
                        err_q   <= (aw_len_i != '0);
`endif
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (w_valid_i) begin
                        wdata_q <= w_data_i;
                        be_q    <= w_strb_i;
`ifdef AXI_WR_RESP_BURST_EN
                        // w_last_i only flags errors; the beat count comes from aw_len_i.
                        if (w_last_i != beat_last) begin
                            err_q <= 1'b1;
                        end
                        if (w_strb_i != '0) begin
                            state_q <= MEM;
                        end else if (beat_last) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= addr_q + BeatBytes;
                        end
`else
                        if (multi_q) begin
                            if (w_last_i) begin
                                state_q <= RESP;
                            end
                        end else begin
                            if (!w_last_i) begin
                                err_q <= 1'b1;
                            end
                            state_q <= (w_strb_i != '0) ? MEM : RESP;
                        end
`endif
                    end
                end
                MEM: begin
                    if (mem_gnt_i) begin
`ifdef AXI_WR_RESP_BURST_EN
                        if (beat_last) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= cnt_q + 8'd1;
                            addr_q  <= addr_q + BeatBytes;
                            state_q <= DATA;
                        end
`else
                        state_q <= RESP;
`endif
                    end
                end
                RESP: begin
                    if (b_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign aw_ready_o  = (state_q == IDLE);
    assign w_ready_o   = (state_q == DATA);
    assign mem_req_o   = (state_q == MEM);
    assign b_valid_o   = (state_q == RESP);
    assign b_id_o      = id_q;
    assign b_resp_o    = {err_q, 1'b0};
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

endmodule

// File: tb/tb_axi_wr_responder.sv
// Directed bench for axi_wr_responder with a scoreboard of expected memory
// writes and B responses. Expectations follow AXI_WR_RESP_BURST_EN.
module tb_axi_wr_responder;

    localparam int IW = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;
`ifdef AXI_WR_RESP_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] be;
    } mem_exp_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          aw_valid_i = 1'b0;
    logic          aw_ready_o;
    logic [IW-1:0] aw_id_i = '0;
    logic [AW-1:0] aw_addr_i = '0;
    logic [7:0]    aw_len_i = '0;
    logic          w_valid_i = 1'b0;
    logic          w_ready_o;
    logic [DW-1:0] w_data_i = '0;
    logic [SW-1:0] w_strb_i = '0;
    logic          w_last_i = 1'b0;
    logic          b_valid_o;
    logic          b_ready_i = 1'b1;
    logic [IW-1:0] b_id_o;
    logic [1:0]    b_resp_o;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b0;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [SW-1:0] mem_be_o;

    int n_checks = 0;
    int n_err    = 0;
    int n_mem    = 0;
    int n_b      = 0;
    int gnt_delay = 0;

    mem_exp_t mem_q[$];
    b_exp_t   b_q[$];

    axi_wr_responder #(
        .AxiIdWidth  (IW),
        .AxiAddrWidth(AW),
        .AxiDataWidth(DW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .aw_id_i    (aw_id_i),
        .aw_addr_i  (aw_addr_i),
        .aw_len_i   (aw_len_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .w_data_i   (w_data_i),
        .w_strb_i   (w_strb_i),
        .w_last_i   (w_last_i),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .b_id_o     (b_id_o),
        .b_resp_o   (b_resp_o),
        .mem_req_o  (mem_req_o),
        .mem_gnt_i  (mem_gnt_i),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o   (mem_be_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_mem(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] be);
        mem_exp_t e;
        e.addr = a;
        e.data = d;
        e.be   = be;
        mem_q.push_back(e);
    endtask

    task automatic push_b(input logic [IW-1:0] id, input logic [1:0] resp);
        b_exp_t e;
        e.id   = id;
        e.resp = resp;
        b_q.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        aw_valid_i = 1'b1;
        aw_id_i    = id;
        aw_addr_i  = addr;
        aw_len_i   = len;
        do begin
            @(negedge clk_i);
            ok = aw_ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end while (!ok && n < 100);
        aw_valid_i = 1'b0;
        chk("aw_handshake", ok, 1'b1);
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        w_valid_i = 1'b1;
        w_data_i  = d;
        w_strb_i  = s;
        w_last_i  = last;
        do begin
            @(negedge clk_i);
            ok = w_ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end while (!ok && n < 100);
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
        chk("w_handshake", ok, 1'b1);
    endtask

    task automatic wait_b_done();
        int n;
        n = 0;
        while (b_q.size() != 0 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        chk("b_done", b_q.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    // Memory grant model: grant after gnt_delay cycles of a pending request.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_req_o && !rst_i) begin
                if (wait_cnt >= gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    mem_gnt_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_gnt_i = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // Output monitor: scoreboard pops on handshakes, stability while stalled.
    initial begin
        mem_exp_t      em;
        b_exp_t        eb;
        logic          mem_wait;
        logic          b_wait;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        logic [SW-1:0] p_be;
        logic [IW-1:0] p_id;
        logic [1:0]    p_resp;
        mem_wait = 1'b0;
        b_wait   = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                mem_wait = 1'b0;
                b_wait   = 1'b0;
            end else begin
                if (mem_req_o) begin
                    if (mem_wait) begin
                        chk("mem_hold_addr", mem_addr_o, p_addr);
                        chk("mem_hold_data", mem_wdata_o, p_data);
                        chk("mem_hold_be", mem_be_o, p_be);
                    end
                    if (mem_gnt_i) begin
                        n_mem++;
                        if (mem_q.size() == 0) begin
                            chk("mem_unexpected", mem_q.size(), 1);
                        end else begin
                            em = mem_q.pop_front();
                            chk("mem_addr", mem_addr_o, em.addr);
                            chk("mem_data", mem_wdata_o, em.data);
                            chk("mem_be", mem_be_o, em.be);
                        end
                    end
                    mem_wait = !mem_gnt_i;
                    p_addr   = mem_addr_o;
                    p_data   = mem_wdata_o;
                    p_be     = mem_be_o;
                end else begin
                    mem_wait = 1'b0;
                end
                if (b_valid_o) begin
                    chk("b_aw_ready_low", aw_ready_o, 1'b0);
                    if (b_wait) begin
                        chk("b_hold_id", b_id_o, p_id);
                        chk("b_hold_resp", b_resp_o, p_resp);
                    end
                    if (b_ready_i) begin
                        n_b++;
                        if (b_q.size() == 0) begin
                            chk("b_unexpected", b_q.size(), 1);
                        end else begin
                            eb = b_q.pop_front();
                            chk("b_id", b_id_o, eb.id);
                            chk("b_resp", b_resp_o, eb.resp);
                        end
                    end
                    b_wait = !b_ready_i;
                    p_id   = b_id_o;
                    p_resp = b_resp_o;
                end else begin
                    b_wait = 1'b0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int nm0;
        int nb0;
        int n;
        logic [SW-1:0] strbs [3];
        strbs = '{8'hFF, 8'h00, 8'h0F};

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("rst_aw_ready", aw_ready_o, 1'b1);
        chk("rst_w_ready", w_ready_o, 1'b0);
        chk("rst_b_valid", b_valid_o, 1'b0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_b_id", b_id_o, 4'h0);
        chk("rst_b_resp", b_resp_o, 2'b00);
        chk("rst_mem_addr", mem_addr_o, 64'h0);
        chk("rst_mem_be", mem_be_o, 8'h00);
        @(posedge clk_i);
        #1;

        // Single beat with immediate grant, latency check
        gnt_delay = 0;
        push_mem(64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF);
        push_b(4'd3, 2'b00);
        aw_send(4'd3, 64'h8000_0004, 8'd0);
        w_send(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        @(negedge clk_i);
        chk("lat_mem_req_c2", mem_req_o, 1'b1);
        chk("lat_mem_addr", mem_addr_o, 64'h8000_0000);
        @(negedge clk_i);
        chk("lat_b_valid_c3", b_valid_o, 1'b1);
        chk("lat_b_id", b_id_o, 4'd3);
        chk("lat_b_resp", b_resp_o, 2'b00);
        wait_b_done();

        // len=3 burst, grant delayed 2 cycles per beat
        gnt_delay = 2;
        nm0 = n_mem;
        if (BURST) begin
            for (int i = 0; i < 4; i++)
                push_mem(64'h1000 + 64'(i * 8), 64'hB000_0000_0000_0000 + 64'(i), 8'hFF);
        end
        push_b(4'd5, BURST ? 2'b00 : 2'b10);
        aw_send(4'd5, 64'h1000, 8'd3);
        for (int i = 0; i < 4; i++)
            w_send(64'hB000_0000_0000_0000 + 64'(i), 8'hFF, (i == 3));
        wait_b_done();
        chk("burst_pulses", n_mem - nm0, BURST ? 4 : 0);

        // Early w_last on beat 1 of a len=3 burst
        gnt_delay = 1;
        nm0 = n_mem;
        if (BURST) begin
            for (int i = 0; i < 4; i++)
                push_mem(64'h2000 + 64'(i * 8), 64'hC000_0000_0000_0000 + 64'(i), 8'hFF);
        end
        push_b(4'd6, 2'b10);
        aw_send(4'd6, 64'h2000, 8'd3);
        for (int i = 0; i < (BURST ? 4 : 2); i++)
            w_send(64'hC000_0000_0000_0000 + 64'(i), 8'hFF, (i == 1));
        wait_b_done();
        chk("early_last_pulses", n_mem - nm0, BURST ? 4 : 0);

        // Middle beat with zero strobes
        gnt_delay = 0;
        nm0 = n_mem;
        if (BURST) begin
            push_mem(64'h3008, 64'hD000_0000_0000_0000, 8'hFF);
            push_mem(64'h3018, 64'hD000_0000_0000_0002, 8'h0F);
        end
        push_b(4'd7, BURST ? 2'b00 : 2'b10);
        aw_send(4'd7, 64'h3008, 8'd2);
        for (int i = 0; i < 3; i++)
            w_send(64'hD000_0000_0000_0000 + 64'(i), strbs[i], (i == 2));
        wait_b_done();
        chk("strb0_pulses", n_mem - nm0, BURST ? 2 : 0);

        // B back-pressure for 5 cycles, next AW waiting
        b_ready_i = 1'b0;
        push_mem(64'h40, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF);
        push_b(4'd9, 2'b00);
        aw_send(4'd9, 64'h44, 8'd0);
        w_send(64'hA5A5_A5A5_5A5A_5A5A, 8'hFF, 1'b1);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!b_valid_o && n < 50);
        push_mem(64'h48, 64'h0000_0000_0000_00EE, 8'h01);
        push_b(4'd10, 2'b00);
        aw_valid_i = 1'b1;
        aw_id_i    = 4'd10;
        aw_addr_i  = 64'h48;
        aw_len_i   = 8'd0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_b_valid", b_valid_o, 1'b1);
            chk("bp_b_id", b_id_o, 4'd9);
            chk("bp_b_resp", b_resp_o, 2'b00);
            chk("bp_aw_ready", aw_ready_o, 1'b0);
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        b_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("bp_aw_ready_after", aw_ready_o, 1'b1);
        chk("bp_b_valid_after", b_valid_o, 1'b0);
        @(posedge clk_i);
        #1;
        aw_valid_i = 1'b0;
        @(negedge clk_i);
        chk("bp_aw_taken", aw_ready_o, 1'b0);
        chk("bp_w_ready", w_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        w_send(64'h0000_0000_0000_00EE, 8'h01, 1'b1);
        wait_b_done();

        // Reset while a memory request waits for grant
        gnt_delay = 1000;
        aw_send(4'hC, 64'h5000, 8'd0);
        w_send(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1);
        @(negedge clk_i);
        chk("rst_pre_req", mem_req_o, 1'b1);
        @(negedge clk_i);
        nb0 = n_b;
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_mid_mem_req", mem_req_o, 1'b0);
        chk("rst_mid_aw_ready", aw_ready_o, 1'b1);
        chk("rst_mid_b_valid", b_valid_o, 1'b0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_rel_aw_ready", aw_ready_o, 1'b1);
        chk("rst_rel_mem_req", mem_req_o, 1'b0);
        gnt_delay = 0;
        repeat (10) @(negedge clk_i);
        chk("rst_no_b", n_b, nb0);
        @(posedge clk_i);
        #1;

        // Missing w_last on a single beat
        push_mem(64'h6000, 64'h0123_4567_89AB_CDEF, 8'h3C);
        push_b(4'd1, 2'b10);
        aw_send(4'd1, 64'h6007, 8'd0);
        w_send(64'h0123_4567_89AB_CDEF, 8'h3C, 1'b0);
        wait_b_done();

        // Address wrap at the top of the address space
        nm0 = n_mem;
        if (BURST) begin
            push_mem(64'hFFFF_FFFF_FFFF_FFF8, 64'hE000_0000_0000_0000, 8'hFF);
            push_mem(64'h0, 64'hE000_0000_0000_0001, 8'hFF);
        end
        push_b(4'd2, BURST ? 2'b00 : 2'b10);
        aw_send(4'd2, 64'hFFFF_FFFF_FFFF_FFF9, 8'd1);
        for (int i = 0; i < 2; i++)
            w_send(64'hE000_0000_0000_0000 + 64'(i), 8'hFF, (i == 1));
        wait_b_done();
        chk("wrap_pulses", n_mem - nm0, BURST ? 2 : 0);

        chk("mem_q_empty", mem_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_wr_responder.md
# axi_wr_responder

AXI4 write-channel responder (subordinate side) that terminates AW/W/B traffic from the core's AXI manager port and turns each write beat into a request on a simple req/gnt memory write port. It is the far end of the write path the write-back data cache uses for evictions and uncached stores, and is used in memory-side subsystems and benches. It handles one transaction at a time, counts beats, and applies byte strobes. It returns OKAY or SLVERR on B.

## Interface
- AxiIdWidth, 4, AW/B ID width
- AxiAddrWidth, 64, address width
- AxiDataWidth, 64, data width; power of two ≥ 32; strobe width is AxiDataWidth/8
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- aw_valid_i  in  1  AW valid
- aw_ready_o  out  1  AW ready
- aw_id_i  in  AxiIdWidth  AW ID
- aw_addr_i  in  AxiAddrWidth  start byte address
- aw_len_i  in  8  beats minus one (INCR, full-width beats)
- w_valid_i  in  1  W valid
- w_ready_o  out  1  W ready
- w_data_i  in  AxiDataWidth  write data
- w_strb_i  in  AxiDataWidth/8  byte strobes
- w_last_i  in  1  last beat marker
- b_valid_o  out  1  B valid
- b_ready_i  in  1  B ready
- b_id_o  out  AxiIdWidth  B ID (= latched AW ID)
- b_resp_o  out  2  2'b00 OKAY, 2'b10 SLVERR
- mem_req_o  out  1  memory write request
- mem_gnt_i  in  1  memory grant (write committed)
- mem_addr_o  out  AxiAddrWidth  beat-aligned byte address
- mem_wdata_o  out  AxiDataWidth  beat data
- mem_be_o  out  AxiDataWidth/8  byte enables (= w_strb_i)

## Operation
- FSM states: IDLE, DATA, MEM, RESP. Outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - aw_ready_o=1.
  - On AW handshake, latch ID, len, and address aligned down to AxiDataWidth/8 bytes. Clear the beat counter and error flag. Go to DATA.
- DATA:
  - w_ready_o=1.
  - On W handshake, register data/strb into the mem_* registers.
  - Compare w_last_i against (cnt==len). A mismatch sets the error flag.
  - If strb≠0: go to MEM.
  - If strb==0: perform no memory access. If it is the last beat, go to RESP; otherwise cnt++, addr += AxiDataWidth/8, stay in DATA.
- MEM:
  - mem_req_o=1. mem_addr_o, mem_wdata_o and mem_be_o are held stable until mem_gnt_i.
  - On grant: if it is the last beat, go to RESP; otherwise cnt++, addr += AxiDataWidth/8, go to DATA.
- RESP:
  - b_valid_o=1. b_id_o and b_resp_o are held stable until b_ready_i; then go to IDLE.
  - b_resp_o = SLVERR if the error flag is set, otherwise OKAY.
- aw_len_i sets the beat count. w_last_i never ends a burst early or late.
- The address increment wraps modulo 2^AxiAddrWidth. 4 KiB crossings are not checked.
- W arriving before AW stalls, because w_ready_o=0 outside DATA.
- Only one transaction is outstanding at a time. aw_ready_o=0 from AW acceptance until the cycle after the B handshake.

## Timing
- Reset values: state IDLE, aw_ready_o=1, all other outputs 0, counters and latches 0.
- rst_i mid-transaction: drop to IDLE immediately (asynchronously). mem_req_o and b_valid_o fall without a grant or handshake. No B is issued for the abandoned transaction.
- Single-beat latency with W presented at cycle 1 and grant given at first request:
  - AW handshake at cycle 0.
  - W handshake at cycle 1.
  - mem_req_o at cycle 2, with grant.
  - b_valid_o at cycle 3.
- Peak throughput is 2 cycles per beat.
- Back-to-back transactions: the next AW is accepted at the earliest one cycle after the B handshake.

## Configuration
- AXI_WR_RESP_BURST_EN defined: aw_len_i 0–255 is supported as described above.
- AXI_WR_RESP_BURST_EN undefined: the beat counter and address incrementer are compiled out.
  - aw_len_i==0 is handled normally.
  - aw_len_i≠0 sets the error flag. All W beats are accepted until a handshake with w_last_i=1, with no mem_req_o. Then B returns SLVERR.

## Test plan
- Single beat, grant given at first request: AW id=3 addr=0x8000_0004 len=0; W data=0x1122334455667788 strb=0xFF last=1 → mem_addr_o=0x8000_0000, mem_be_o=0xFF. b_valid_o at cycle 3 with b_id_o=3, b_resp_o=00.
- Burst (macro defined): AW addr=0x1000 len=3, grant delayed 2 cycles per beat → mem_addr_o 0x1000, 0x1008, 0x1010, 0x1018, data held stable while waiting; one B OKAY. Macro undefined, same stimulus → no mem_req_o; B SLVERR after the 4th beat.
- w_last_i=1 on beat 1 of a len=3 burst → all 4 beats written; b_resp_o=10.
- Middle beat with strb=0x00 in a len=2 burst → exactly 2 mem_req_o pulses; B OKAY.
- b_ready_i held low 5 cycles → b_valid_o, b_id_o and b_resp_o stable; aw_ready_o=0 throughout. A new AW is accepted the cycle after the handshake.
- rst_i pulsed while in MEM with mem_gnt_i=0 → mem_req_o falls during reset; aw_ready_o=1 after release; no B ever issued.
